pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Sequencer and lock supervisor for the system PLL (50 MHz refclk in; 100/50/25 MHz outputs). It drives the PLL reset, waits for and qualifies `locked`, then releases per-clock-domain resets in a fixed staggered order. It tears everything down on a filtered loss of lock or a software restart. It runs on the free-running reference clock and sits between the board reset and every PLL-clocked domain.

## Interface
Parameters:
- `NUM_DOMAINS`, default 3: number of domain reset outputs; index 0 is released first.
- `PLL_RST_CYCLES`, default 16: `pll_rst` assertion length in refclk cycles; must be ≥1.
- `LOCK_TIMEOUT`, default 50000: cycles to wait for lock before retrying; must be ≥2.
- `LOCK_STABLE`, default 1024: consecutive locked cycles required before any release; must be ≥1.
- `STAGGER`, default 8: cycles between successive domain releases; must be ≥1.
- `LOSS_FILTER`, default 4: consecutive unlocked cycles that count as lock loss; must be ≥1.
- `MAX_RETRIES`, default 7: retry count at which `fail` sets; must be ≤255.

Ports:
- `refclk`, in, 1: sole clock, 50 MHz reference.
- `rst_n`, in, 1: asynchronous active-low reset.
- `locked`, in, 1: PLL lock. Asynchronous to `refclk`.
- `restart_req`, in, 1: single-cycle request for a full re-sequence.
- `pll_rst`, out, 1: drives the PLL `rst` input; active high.
- `rst_out_n`, out, NUM_DOMAINS: per-domain resets; active low.
- `ready`, out, 1: all domains released and the PLL is running.
- `retry_cnt`, out, 8: lock-timeout count; saturates at 255.
- `fail`, out, 1: sticky; set when `retry_cnt` reaches `MAX_RETRIES`.

## Operation
- `locked` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- States:
  - S_PLLRST: `pll_rst`=1. Counts `PLL_RST_CYCLES` cycles, then goes to S_WAIT_LOCK.
  - S_WAIT_LOCK: `pll_rst`=0.
    - `lock_s`=1 → S_STABLE.
    - Otherwise, after `LOCK_TIMEOUT` cycles → S_PLLRST, `retry_cnt`+1 (saturating), and `fail` sets if the new count ≥ `MAX_RETRIES`.
  - S_STABLE: `lock_s`=0 → S_WAIT_LOCK with the timeout counter cleared; no retry is charged. After `LOCK_STABLE` consecutive cycles with `lock_s`=1 → S_RELEASE.
  - S_RELEASE: the transition edge into S_RELEASE sets `rst_out_n[0]`. `rst_out_n[i]` sets `STAGGER` cycles after `rst_out_n[i-1]`. The edge that sets `rst_out_n[NUM_DOMAINS-1]` also sets `ready` and enters S_RUN.
  - S_RUN: steady state.
- Loss filter (S_RELEASE, S_RUN only):
  - Counts consecutive cycles with `lock_s`=0; any `lock_s`=1 clears the count.
  - On reaching `LOSS_FILTER`, at the same edge: all `rst_out_n`=0, `ready`=0, go to S_PLLRST. No retry is charged.
- `restart_req` in any state other than S_PLLRST has the same effect as a lock loss, on the next edge. In S_PLLRST it is ignored.
- Simultaneous events: `restart_req` takes priority over a timeout in the same cycle, so no retry is charged. A restart and a filtered loss together produce one teardown.
- `retry_cnt` and `fail` clear only on `rst_n`.
- Counters are `$clog2(max(param))+1` bits wide and are cleared on every state entry. `rst_out_n` bits, once set, only clear together.

## Timing
- Reset values: `pll_rst`=1, `rst_out_n`=0, `ready`=0, `retry_cnt`=0, `fail`=0, state S_PLLRST. All outputs are registered and glitch-free.
- `rst_n` assertion forces these values immediately. This applies mid-release too: partially released domains re-assert at once.
- `locked`→`lock_s` latency: 2 edges. S_STABLE is entered on the first edge that samples `lock_s`=1.
- From S_RELEASE entry to `ready`: (NUM_DOMAINS-1)·STAGGER cycles.
- Teardown latency from the first unlocked `lock_s` cycle: `LOSS_FILTER` edges.
- `rst_out_n` deassertion is synchronous to `refclk`. Each destination domain re-synchronizes it locally; that logic is outside this block.

## Structure
- Shared package `pll_seq_pkg` holds:
  - state enum `pll_seq_state_t`;
  - default parameter constants;
  - `RETRY_W`=8.
- One sub-module, `pll_lock_sync`: a 2-flop synchronizer with async active-low reset that clears to 0.
- The FSM, counters and loss filter live in the top level.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=8, LOCK_TIMEOUT=64, LOCK_STABLE=16, STAGGER=4, LOSS_FILTER=3, MAX_RETRIES=2, NUM_DOMAINS=3.
1. `rst_n` release, then `locked` high 20 cycles later → `pll_rst` high for exactly 8 cycles. `rst_out_n` goes 001, 011, 111 at 4-cycle spacing; `ready`=1 with the third bit; `retry_cnt`=0.
2. `locked` held low → `pll_rst` re-pulses every 8+64 cycles; `retry_cnt` reads 1, then 2; `fail`=1 at 2; `retry_cnt` saturates at 255 on a long run.
3. In S_RUN, `locked` low for 2 cycles, then high → no change. Low for 3 cycles → `rst_out_n`=000 and `ready`=0 three edges after `lock_s` falls, then a full re-sequence.
4. In S_STABLE, a 1-cycle `locked` dropout → return to S_WAIT_LOCK, no release, `retry_cnt` unchanged; release happens 16 clean cycles after relock.
5. `restart_req` pulse in S_RUN, and a second one on the same cycle as a timeout → teardown, `retry_cnt` unchanged in both cases.
6. `rst_n` asserted between `rst_out_n[0]` and `rst_out_n[1]` release → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer: FSM state encoding,
// default timing constants and the retry counter width.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } pll_seq_state_t;

    localparam int DEF_NUM_DOMAINS    = 3;
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 50000;
    localparam int DEF_LOCK_STABLE    = 1024;
    localparam int DEF_STAGGER        = 8;
    localparam int DEF_LOSS_FILTER    = 4;
    localparam int DEF_MAX_RETRIES    = 7;

    localparam int RETRY_W = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the
// reference clock domain; clears to 0 so lock is never assumed out of reset.
module pll_lock_sync (
    input  logic refclk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge refclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, qualifies
// lock, releases domain resets in staggered order and tears down on loss.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
    parameter int STAGGER        = DEF_STAGGER,
    parameter int LOSS_FILTER    = DEF_LOSS_FILTER,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    input  logic                   locked,
    input  logic                   restart_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out_n,
    output logic                   ready,
    output logic [RETRY_W-1:0]     retry_cnt,
    output logic                   fail
);

    localparam int CNT_MAX = max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                       max2(LOCK_STABLE, STAGGER)), LOSS_FILTER);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]   PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0]   LOSS_LAST    = CNT_W'(LOSS_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic [NUM_DOMAINS-1:0] rst_shift;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic                   fail_q, fail_d;
    logic                   pll_rst_q;
    logic                   ready_q;
    logic                   lock_s;
    logic                   teardown;

    pll_lock_sync u_lock_sync (
        .refclk_i (refclk),
        .rst_n_i  (rst_n),
        .async_i  (locked),
        .sync_o   (lock_s)
    );

    // Released domains form a thermometer code growing from bit 0.
    assign rst_shift = (rst_out_q << 1) | NUM_DOMAINS'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        loss_d    = '0;
        rst_out_d = rst_out_q;
        retry_d   = retry_q;
        fail_d    = fail_q;
        teardown  = 1'b0;

        case (state_q)
            S_PLLRST: begin
                if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLLRST;
                    retry_d = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
                    fail_d  = fail_q | (retry_d >= RETRY_LIMIT);
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    rst_out_d = rst_shift;
                    state_d   = rst_shift[NUM_DOMAINS-1] ? S_RUN : S_RELEASE;
                end
            end
            S_RELEASE: begin
                loss_d = lock_s ? '0 : loss_q + 1'b1;
                if (cnt_q == STAGGER_LAST) begin
                    rst_out_d = rst_shift;
                    cnt_d     = '0;
                    if (rst_shift[NUM_DOMAINS-1]) state_d = S_RUN;
                end
            end
            S_RUN: begin
                loss_d = lock_s ? '0 : loss_q + 1'b1;
                cnt_d  = cnt_q;
            end
            default: state_d = S_PLLRST;
        endcase

        if ((state_q == S_RELEASE || state_q == S_RUN) && !lock_s && loss_q == LOSS_LAST)
            teardown = 1'b1;
        if (restart_req && state_q != S_PLLRST)
            teardown = 1'b1;

        // A teardown overrides any concurrent timeout, so no retry is charged.
        if (teardown) begin
            state_d   = S_PLLRST;
            rst_out_d = '0;
            retry_d   = retry_q;
            fail_d    = fail_q;
            loss_d    = '0;
        end

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            loss_q    <= '0;
            rst_out_q <= '0;
            retry_q   <= '0;
            fail_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            rst_out_q <= rst_out_d;
            retry_q   <= retry_d;
            fail_q    <= fail_d;
            pll_rst_q <= (state_d == S_PLLRST);
            ready_q   <= (state_d == S_RUN);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign rst_out_n = rst_out_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed, table-driven bench for the PLL reset sequencer using the reduced
// timing set (8/64/16/4/3, two retries, three domains).
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst;
    logic [2:0] rst_out_n;
    logic       ready;
    logic [7:0] retry_cnt;
    logic       fail;

    int n_vec = 0;
    int n_bad = 0;

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .NUM_DOMAINS    (3),
        .PLL_RST_CYCLES (8),
        .LOCK_TIMEOUT   (64),
        .LOCK_STABLE    (16),
        .STAGGER        (4),
        .LOSS_FILTER    (3),
        .MAX_RETRIES    (2)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .locked      (locked),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .rst_out_n   (rst_out_n),
        .ready       (ready),
        .retry_cnt   (retry_cnt),
        .fail        (fail)
    );

    // One record: optional reset, inputs to hold, edges to advance, expected outputs.
    typedef struct {
        bit         do_rst;
        bit         lk;
        bit         rq;
        int         steps;
        bit         e_pll;
        logic [2:0] e_rst;
        bit         e_rdy;
        logic [7:0] e_retry;
        bit         e_fail;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit do_rst, input bit lk, input bit rq, input int steps,
                       input bit e_pll, input logic [2:0] e_rst, input bit e_rdy,
                       input logic [7:0] e_retry, input bit e_fail, input string name);
        vec_t v;
        v.do_rst = do_rst; v.lk = lk; v.rq = rq; v.steps = steps;
        v.e_pll = e_pll; v.e_rst = e_rst; v.e_rdy = e_rdy;
        v.e_retry = e_retry; v.e_fail = e_fail; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    task automatic do_reset(input bit lk);
        rst_n = 1'b0;
        locked = lk;
        restart_req = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input bit e_pll, input logic [2:0] e_rst,
                         input bit e_rdy, input logic [7:0] e_retry, input bit e_fail);
        n_vec++;
        if (pll_rst !== e_pll || rst_out_n !== e_rst || ready !== e_rdy ||
            retry_cnt !== e_retry || fail !== e_fail) begin
            n_bad++;
            $display("FAIL %s: got pll_rst=%b rst_out_n=%b ready=%b retry_cnt=%0d fail=%b, want pll_rst=%b rst_out_n=%b ready=%b retry_cnt=%0d fail=%b",
                     name, pll_rst, rst_out_n, ready, retry_cnt, fail,
                     e_pll, e_rst, e_rdy, e_retry, e_fail);
        end else begin
            $display("vec %0d %s: pll_rst=%b rst_out_n=%b ready=%b retry_cnt=%0d fail=%b",
                     n_vec, name, pll_rst, rst_out_n, ready, retry_cnt, fail);
        end
    endtask

    initial begin
        // Edge numbers in names count rising edges since rst_n release.
        // Lock qualification, staggered release, loss filter, restart in RUN.
        add(1,0,0, 0, 1,3'b000,0,0,0, "s1_reset_state");
        add(0,0,0, 7, 1,3'b000,0,0,0, "s1_pllrst_e7");
        add(0,0,0, 1, 0,3'b000,0,0,0, "s1_pllrst_done_e8");
        add(0,0,0,11, 0,3'b000,0,0,0, "s1_wait_e19");
        add(0,1,0,18, 0,3'b000,0,0,0, "s1_stable_e37");
        add(0,1,0, 1, 0,3'b001,0,0,0, "s1_dom0_e38");
        add(0,1,0, 3, 0,3'b001,0,0,0, "s1_dom0_e41");
        add(0,1,0, 1, 0,3'b011,0,0,0, "s1_dom1_e42");
        add(0,1,0, 3, 0,3'b011,0,0,0, "s1_dom1_e45");
        add(0,1,0, 1, 0,3'b111,1,0,0, "s1_ready_e46");
        add(0,0,0, 2, 0,3'b111,1,0,0, "s3_glitch2_e48");
        add(0,1,0, 6, 0,3'b111,1,0,0, "s3_no_teardown_e54");
        add(0,0,0, 3, 0,3'b111,1,0,0, "s3_low3_e57");
        add(0,1,0, 1, 0,3'b111,1,0,0, "s3_filtering_e58");
        add(0,1,0, 1, 1,3'b000,0,0,0, "s3_teardown_e59");
        add(0,1,0, 7, 1,3'b000,0,0,0, "s3_pllrst_e66");
        add(0,1,0, 1, 0,3'b000,0,0,0, "s3_wait_e67");
        add(0,1,0,16, 0,3'b000,0,0,0, "s3_stable_e83");
        add(0,1,0, 1, 0,3'b001,0,0,0, "s3_dom0_e84");
        add(0,1,0, 8, 0,3'b111,1,0,0, "s3_ready_e92");
        add(0,1,1, 1, 1,3'b000,0,0,0, "s5_restart_run_e93");
        add(0,1,0, 8, 0,3'b000,0,0,0, "s5_wait_e101");
        add(0,1,0,25, 0,3'b111,1,0,0, "s5_ready_e126");
        // Lock never arrives: retries, sticky fail, saturation.
        add(1,0,0, 0, 1,3'b000,0,  0,0, "s2_reset_state");
        add(0,0,0, 8, 0,3'b000,0,  0,0, "s2_wait_e8");
        add(0,0,0,63, 0,3'b000,0,  0,0, "s2_wait_e71");
        add(0,0,0, 1, 1,3'b000,0,  1,0, "s2_retry1_e72");
        add(0,0,0, 7, 1,3'b000,0,  1,0, "s2_pllrst_e79");
        add(0,0,0, 1, 0,3'b000,0,  1,0, "s2_wait_e80");
        add(0,0,0,64, 1,3'b000,0,  2,1, "s2_retry2_fail_e144");
        add(0,0,0,18215, 0,3'b000,0,254,1, "s2_retry254_e18359");
        add(0,0,0, 1, 1,3'b000,0,255,1, "s2_retry255_e18360");
        add(0,0,0,144, 1,3'b000,0,255,1, "s2_saturated_e18504");
        // Restart ignored in S_PLLRST; restart coinciding with a timeout.
        add(1,0,0, 2, 1,3'b000,0,0,0, "s5_reset_clears_retry");
        add(0,0,1, 6, 0,3'b000,0,0,0, "s5_restart_in_pllrst_ignored_e8");
        add(0,0,0,63, 0,3'b000,0,0,0, "s5_wait_e71");
        add(0,0,1, 1, 1,3'b000,0,0,0, "s5_restart_on_timeout_e72");
        add(0,0,0,71, 0,3'b000,0,0,0, "s5_wait_e143");
        add(0,0,0, 1, 1,3'b000,0,1,0, "s5_timeout_e144");
        // One-cycle dropout in S_STABLE restarts qualification.
        add(1,1,0,14, 0,3'b000,0,0,0, "s4_stable_e14");
        add(0,0,0, 1, 0,3'b000,0,0,0, "s4_dropout_e15");
        add(0,1,0,18, 0,3'b000,0,0,0, "s4_no_release_e33");
        add(0,1,0, 1, 0,3'b001,0,0,0, "s4_dom0_e34");
        add(0,1,0, 8, 0,3'b111,1,0,0, "s4_ready_e42");

        @(negedge refclk);
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) do_reset(vecs[i].lk);
            locked = vecs[i].lk;
            restart_req = vecs[i].rq;
            for (int s = 0; s < vecs[i].steps; s++) begin
                step();
                restart_req = 1'b0;
            end
            restart_req = 1'b0;
            check(vecs[i].name, vecs[i].e_pll, vecs[i].e_rst, vecs[i].e_rdy,
                  vecs[i].e_retry, vecs[i].e_fail);
        end

        // Asynchronous reset between the first and second domain release.
        do_reset(1'b1);
        for (int s = 0; s < 25; s++) step();
        check("s6_dom0_e25", 1'b0, 3'b001, 1'b0, 8'd0, 1'b0);
        step();
        check("s6_dom0_e26", 1'b0, 3'b001, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("s6_async_assert", 1'b1, 3'b000, 1'b0, 8'd0, 1'b0);
        step();
        step();
        check("s6_held_in_reset", 1'b1, 3'b000, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        for (int s = 0; s < 8; s++) step();
        check("s6_resequence_e8", 1'b0, 3'b000, 1'b0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
